// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_reset_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN
  } state_t;

  // Event counters stop here instead of wrapping back to zero.
  localparam logic [7:0] SAT_MAX = 8'hFF;

  // Width of the shared cycle counter: enough to hold (largest limit - 1).
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_bit_sync.sv
// Multi-flop synchroniser for a single asynchronous level signal.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // Shift the asynchronous input through the flop chain; oldest sample leaves at the top.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments make every stage take its neighbour's old value on the same edge.
    if (i_rst) r_chain <= '0;
    else       r_chain <= {r_chain[STAGES-2:0], i_d};
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Supervises the core PLL from the reference clock: pulses the PLL reset,
// qualifies lock, then releases domain resets one by one at a fixed spacing.
module pll_reset_sequencer
  import pll_reset_pkg::*;
#(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int NUM_DOMAINS         = 4,
  parameter int STAGE_GAP_CYCLES    = 8
) (
  input  logic                   refclk,
  input  logic                   rst,
  input  logic                   pll_locked,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   ready,
  output logic [7:0]             relock_count,
  output logic [7:0]             timeout_count
);

  localparam int CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
                                   LOCK_TIMEOUT_CYCLES, STAGE_GAP_CYCLES);
  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] C_RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_GAP_LAST     = CNT_W'(STAGE_GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] C_IDX_LAST     = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [IDX_W-1:0] C_IDX_FIRST    = IDX_W'(1);

  logic                   w_locked_s;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_pll_rst;
  logic [NUM_DOMAINS-1:0] r_domain_rst;
  logic                   r_ready;
  logic [7:0]             r_relock_count;
  logic [7:0]             r_timeout_count;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .i_clk (refclk),
    .i_rst (rst),
    .i_d   (pll_locked),
    .o_q   (w_locked_s)
  );

  // Sequencer FSM: every output is a flop updated alongside the state.
  always_ff @(posedge refclk) begin
    // NOTE: reset is sampled on the clock edge only, so it must be held across at least one refclk edge.
    if (rst) begin
      r_state         <= PLL_RST;
      r_cnt           <= '0;
      r_idx           <= '0;
      r_pll_rst       <= 1'b1;
      r_domain_rst    <= '1;
      r_ready         <= 1'b0;
      r_relock_count  <= '0;
      r_timeout_count <= '0;
    end else begin
      case (r_state)
        PLL_RST: begin
          r_pll_rst    <= 1'b1;
          r_domain_rst <= '1;
          r_ready      <= 1'b0;
          if (r_cnt == C_RST_LAST) begin
            r_state   <= WAIT_LOCK;
            r_cnt     <= '0;
            r_pll_rst <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        WAIT_LOCK: begin
          if (w_locked_s) begin
            r_state <= STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == C_TIMEOUT_LAST) begin
            r_state   <= PLL_RST;
            r_cnt     <= '0;
            r_pll_rst <= 1'b1;
            if (r_timeout_count != SAT_MAX) r_timeout_count <= r_timeout_count + 8'd1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        STABLE: begin
          if (!w_locked_s) begin
            // Any dropout restarts both qualification and the timeout window.
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == C_STABLE_LAST) begin
            r_cnt        <= '0;
            r_idx        <= C_IDX_FIRST;
            r_domain_rst <= r_domain_rst << 1;
            if (NUM_DOMAINS == 1) begin
              r_ready <= 1'b1;
              r_state <= RUN;
            end else begin
              r_state <= RELEASE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        RELEASE: begin
          if (!w_locked_s) begin
            r_state      <= PLL_RST;
            r_cnt        <= '0;
            r_pll_rst    <= 1'b1;
            r_domain_rst <= '1;
            r_ready      <= 1'b0;
            if (r_relock_count != SAT_MAX) r_relock_count <= r_relock_count + 8'd1;
          end else if (r_cnt == C_GAP_LAST) begin
            // Released bits are all low bits, so a left shift clears the next one in order.
            r_cnt        <= '0;
            r_idx        <= r_idx + 1'b1;
            r_domain_rst <= r_domain_rst << 1;
            if (r_idx == C_IDX_LAST) begin
              r_ready <= 1'b1;
              r_state <= RUN;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        RUN: begin
          if (!w_locked_s) begin
            r_state      <= PLL_RST;
            r_cnt        <= '0;
            r_pll_rst    <= 1'b1;
            r_domain_rst <= '1;
            r_ready      <= 1'b0;
            if (r_relock_count != SAT_MAX) r_relock_count <= r_relock_count + 8'd1;
          end
        end

        default: begin
          r_state      <= PLL_RST;
          r_cnt        <= '0;
          r_pll_rst    <= 1'b1;
          r_domain_rst <= '1;
          r_ready      <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst       = r_pll_rst;
  assign domain_rst    = r_domain_rst;
  assign ready         = r_ready;
  assign relock_count  = r_relock_count;
  assign timeout_count = r_timeout_count;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer against a run-length reference model.
module tb_pll_reset_sequencer;

  localparam int P_SYNC    = 2;
  localparam int P_RST     = 4;
  localparam int P_STABLE  = 8;
  localparam int P_TIMEOUT = 32;
  localparam int P_DOM     = 4;
  localparam int P_GAP     = 2;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_rst;
  logic [3:0] domain_rst;
  logic       ready;
  logic [7:0] relock_count;
  logic [7:0] timeout_count;

  int checks = 0;
  int errors = 0;

  pll_reset_sequencer #(
    .SYNC_STAGES         (P_SYNC),
    .PLL_RST_CYCLES      (P_RST),
    .LOCK_STABLE_CYCLES  (P_STABLE),
    .LOCK_TIMEOUT_CYCLES (P_TIMEOUT),
    .NUM_DOMAINS         (P_DOM),
    .STAGE_GAP_CYCLES    (P_GAP)
  ) dut (
    .refclk        (refclk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .pll_rst       (pll_rst),
    .domain_rst    (domain_rst),
    .ready         (ready),
    .relock_count  (relock_count),
    .timeout_count (timeout_count)
  );

  always #10 refclk = ~refclk;

  // Reference model. Phases: 0 = PLL held in reset, 1 = waiting/qualifying lock,
  // 2 = domains released (e = edges since the first domain came out of reset).
  int          m_phase;
  int          m_t;
  int          m_w;
  int          m_run;
  int          m_e;
  int          m_relock;
  int          m_timeout;
  logic [1:0]  m_sync;

  task automatic model_edge(input logic r, input logic l);
    logic ls;
    if (r) begin
      m_phase = 0; m_t = 0; m_w = 0; m_run = 0; m_e = 0;
      m_relock = 0; m_timeout = 0; m_sync = 2'b00;
      return;
    end
    ls     = m_sync[1];
    m_sync = {m_sync[0], l};
    case (m_phase)
      0: begin
        m_t++;
        if (m_t >= P_RST) begin m_phase = 1; m_w = 0; m_run = 0; end
      end
      1: begin
        if (ls) begin
          m_run++;
          if (m_run > P_STABLE) begin m_phase = 2; m_e = 0; end
        end else if (m_run > 0) begin
          m_run = 0; m_w = 0;
        end else begin
          m_w++;
          if (m_w >= P_TIMEOUT) begin
            m_phase = 0; m_t = 0;
            if (m_timeout < 255) m_timeout++;
          end
        end
      end
      default: begin
        if (!ls) begin
          m_phase = 0; m_t = 0;
          if (m_relock < 255) m_relock++;
        end else if (m_e < 1000) begin
          m_e++;
        end
      end
    endcase
  endtask

  function automatic logic [3:0] exp_dom();
    logic [3:0] d;
    d = 4'hF;
    if (m_phase == 2)
      for (int k = 0; k < P_DOM; k++) d[k] = (m_e < k * P_GAP);
    return d;
  endfunction

  function automatic logic exp_ready();
    return (m_phase == 2) && (m_e >= (P_DOM - 1) * P_GAP);
  endfunction

  task automatic check_all(input string tag);
    logic       e_pll;
    logic [3:0] e_dom;
    logic       e_rdy;
    e_pll = (m_phase == 0);
    e_dom = exp_dom();
    e_rdy = exp_ready();
    checks++;
    assert (pll_rst === e_pll) else begin
      errors++; $error("FAIL %s pll_rst got %b exp %b", tag, pll_rst, e_pll);
    end
    checks++;
    assert (domain_rst === e_dom) else begin
      errors++; $error("FAIL %s domain_rst got %b exp %b", tag, domain_rst, e_dom);
    end
    checks++;
    assert (ready === e_rdy) else begin
      errors++; $error("FAIL %s ready got %b exp %b", tag, ready, e_rdy);
    end
    checks++;
    assert (relock_count === 8'(m_relock)) else begin
      errors++; $error("FAIL %s relock_count got %0d exp %0d", tag, relock_count, m_relock);
    end
    checks++;
    assert (timeout_count === 8'(m_timeout)) else begin
      errors++; $error("FAIL %s timeout_count got %0d exp %0d", tag, timeout_count, m_timeout);
    end
  endtask

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++; $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // One refclk edge with the given inputs, then outputs checked 1 ns later.
  task automatic step(input logic r, input logic l, input string tag);
    rst        = r;
    pll_locked = l;
    @(posedge refclk);
    model_edge(r, l);
    #1;
    check_all(tag);
  endtask

  initial begin
    int drop_len;
    int seg_len;
    int total;
    logic lv;

    // Reset state.
    repeat (3) step(1'b1, 1'b0, "reset");
    check_eq("reset_pll_rst", {7'd0, pll_rst}, 8'd1);
    check_eq("reset_domain_rst", {4'd0, domain_rst}, 8'h0F);
    check_eq("reset_ready", {7'd0, ready}, 8'd0);
    check_eq("reset_counts", relock_count | timeout_count, 8'd0);

    // Clean bring-up: lock rises on the 10th edge after reset release.
    repeat (9) step(1'b0, 1'b0, "bringup_wait");
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, "bringup");
    check_eq("bringup_ready", {7'd0, ready}, 8'd1);
    check_eq("bringup_domains", {4'd0, domain_rst}, 8'h00);
    check_eq("bringup_counts", relock_count | timeout_count, 8'd0);

    // Lock loss while running, then a normal re-sequence.
    drop_len = $urandom_range(1, 4);
    for (int i = 0; i < drop_len; i++) step(1'b0, 1'b0, "run_loss");
    for (int i = 0; i < 60; i++) step(1'b0, 1'b1, "run_relock");
    check_eq("run_loss_relock", relock_count, 8'd1);
    check_eq("run_loss_ready", {7'd0, ready}, 8'd1);

    // Lock loss mid-release, after domain_rst reaches 4'b1100.
    step(1'b0, 1'b0, "mid_prep");
    for (int i = 0; i < 80 && exp_dom() != 4'b1100; i++) step(1'b0, 1'b1, "mid_seq");
    check_eq("mid_pattern", {4'd0, domain_rst}, 8'h0C);
    repeat (3) step(1'b0, 1'b0, "mid_loss");
    check_eq("mid_domains", {4'd0, domain_rst}, 8'h0F);
    check_eq("mid_relock", relock_count, 8'd3);
    for (int i = 0; i < 60; i++) step(1'b0, 1'b1, "mid_recover");

    // Qualification glitch 5 cycles into STABLE.
    step(1'b1, 1'b0, "glitch_rst");
    for (int i = 0; i < 60 && !(m_phase == 1 && m_run == 6); i++)
      step(1'b0, ($urandom_range(0, 1) == 1) || (i > 8), "glitch_pre");
    step(1'b0, 1'b0, "glitch_drop");
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, "glitch_post");
    check_eq("glitch_relock", relock_count, 8'd0);
    check_eq("glitch_ready", {7'd0, ready}, 8'd1);

    // Randomized lock activity with occasional resets.
    total = 0;
    while (total < 1500) begin
      lv      = ($urandom_range(0, 3) != 0);
      seg_len = $urandom_range(1, 40);
      for (int i = 0; i < seg_len; i++)
        step(($urandom_range(0, 199) == 0), lv, "random");
      total += seg_len;
    end

    // Timeout saturation with lock never arriving.
    step(1'b1, 1'b0, "sat_rst");
    for (int i = 0; i < 300 * (P_RST + P_TIMEOUT) + 10; i++) step(1'b0, 1'b0, "sat");
    check_eq("sat_timeout", timeout_count, 8'hFF);
    check_eq("sat_domains", {4'd0, domain_rst}, 8'h0F);

    // rst asserted mid-release.
    step(1'b1, 1'b0, "midrst_rst");
    for (int i = 0; i < 60 && !(m_phase == 2 && m_e == 3); i++) step(1'b0, 1'b1, "midrst_seq");
    check_eq("midrst_partial", {4'd0, domain_rst}, 8'h0C);
    step(1'b1, 1'b1, "midrst_hit");
    check_eq("midrst_pll_rst", {7'd0, pll_rst}, 8'd1);
    check_eq("midrst_domains", {4'd0, domain_rst}, 8'h0F);
    check_eq("midrst_counts", relock_count | timeout_count, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
